hsi_mse_sched: RTL and testbench

// - Per-pixel sequencer for the MSE min/max comparator. On start it clears the comparator,

---
 rtl/hsi_mse_sched.sv | 230 +++++++++++++++++++++++
 tb/tb_hsi_mse_sched.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hsi_mse_sched.sv
// Per-pixel sequencer between the pixel front-end and the MSE datapath / min-max comparator pair.
// Optional build macro HSI_MSE_SCHED_ORDER_CHECK_EN adds an in-order check on returned result refs.
module hsi_mse_sched #(
    parameter int WORD_WIDTH            = 32,
    parameter int HSI_LIBRARY_SIZE      = 256,
    parameter int HSI_LIBRARY_SIZE_ADDR = $clog2(HSI_LIBRARY_SIZE)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [HSI_LIBRARY_SIZE_ADDR:0]   lib_size,
    output logic                             busy,
    output logic                             error,
    output logic                             ref_req_valid,
    input  logic                             ref_req_ready,
    output logic [HSI_LIBRARY_SIZE_ADDR-1:0] ref_req_addr,
    input  logic                             mse_res_valid,
    input  logic [WORD_WIDTH-1:0]            mse_res_value,
    input  logic [HSI_LIBRARY_SIZE_ADDR-1:0] mse_res_ref,
    output logic                             comp_clear,
    output logic                             comp_in_valid,
    output logic [WORD_WIDTH-1:0]            comp_in_value,
    output logic [HSI_LIBRARY_SIZE_ADDR-1:0] comp_in_ref,
    input  logic [WORD_WIDTH-1:0]            comp_min_value,
    input  logic [HSI_LIBRARY_SIZE_ADDR-1:0] comp_min_ref,
    input  logic [WORD_WIDTH-1:0]            comp_max_value,
    input  logic [HSI_LIBRARY_SIZE_ADDR-1:0] comp_max_ref,
    output logic                             done,
    output logic [WORD_WIDTH-1:0]            min_value,
    output logic [HSI_LIBRARY_SIZE_ADDR-1:0] min_ref,
    output logic [WORD_WIDTH-1:0]            max_value,
    output logic [HSI_LIBRARY_SIZE_ADDR-1:0] max_ref
);

    localparam int AW = HSI_LIBRARY_SIZE_ADDR;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] LIB_MAX  = CW'(HSI_LIBRARY_SIZE);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_FLUSH = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic [CW-1:0]           issue_cnt_r;
    logic [CW-1:0]           rx_cnt_r;
    logic [CW-1:0]           rx_next_s;
    logic [CW-1:0]           lib_size_r;
    logic                    busy_r;
    logic                    req_valid_r;
    logic                    clear_r;
    logic                    done_r;
    logic                    error_r;
    logic [WORD_WIDTH-1:0]   min_value_r;
    logic [AW-1:0]           min_ref_r;
    logic [WORD_WIDTH-1:0]   max_value_r;
    logic [AW-1:0]           max_ref_r;

    logic                    size_ok_s;
    logic                    start_ok_s;
    logic                    start_bad_s;
    logic                    fwd_window_s;
    logic                    res_accept_s;
    logic                    res_drop_s;
    logic                    req_fire_s;
    logic                    order_err_s;
    logic                    err_set_s;

    assign size_ok_s    = (lib_size != CNT_ZERO) && (lib_size <= LIB_MAX);
    assign start_ok_s   = (state_r == S_IDLE) && start && size_ok_s;
    assign start_bad_s  = (state_r == S_IDLE) && start && !size_ok_s;
    assign fwd_window_s = (state_r == S_ISSUE) || (state_r == S_WAIT);
    // Results beyond the expected count are treated like out-of-window strays.
    assign res_accept_s = mse_res_valid && fwd_window_s && (rx_cnt_r < lib_size_r);
    assign res_drop_s   = mse_res_valid && !res_accept_s;
    assign req_fire_s   = (state_r == S_ISSUE) && ref_req_ready;
    assign rx_next_s    = res_accept_s ? (rx_cnt_r + CNT_ONE) : rx_cnt_r;

`ifdef HSI_MSE_SCHED_ORDER_CHECK_EN
    assign order_err_s  = res_accept_s && (mse_res_ref != rx_cnt_r[AW-1:0]);
`else
    assign order_err_s  = 1'b0;
`endif

    assign err_set_s    = start_bad_s || res_drop_s || order_err_s;

    // Next-state decode for the per-pixel sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start_ok_s) begin
                    state_s = S_CLEAR;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_CLEAR: begin
                state_s = S_ISSUE;
            end
            S_ISSUE: begin
                if (req_fire_s && (issue_cnt_r == (lib_size_r - CNT_ONE))) begin
                    state_s = S_WAIT;
                end else begin
                    state_s = S_ISSUE;
                end
            end
            S_WAIT: begin
                // The result accepted this cycle counts toward completion.
                if ((issue_cnt_r == lib_size_r) && (rx_next_s == lib_size_r)) begin
                    state_s = S_FLUSH;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_FLUSH: begin
                state_s = S_DONE;
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State register plus control outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            busy_r      <= 1'b0;
            req_valid_r <= 1'b0;
            clear_r     <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            busy_r      <= (state_s != S_IDLE);
            req_valid_r <= (state_s == S_ISSUE);
            clear_r     <= (state_s == S_CLEAR);
            done_r      <= (state_s == S_DONE);
        end
    end

    // Issue and receive counters; one bit wider than the address so a full library does not wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue_cnt_r <= CNT_ZERO;
            rx_cnt_r    <= CNT_ZERO;
        end else if (state_r == S_CLEAR) begin
            issue_cnt_r <= CNT_ZERO;
            rx_cnt_r    <= CNT_ZERO;
        end else begin
            if (req_fire_s) begin
                issue_cnt_r <= issue_cnt_r + CNT_ONE;
            end else begin
                issue_cnt_r <= issue_cnt_r;
            end
            rx_cnt_r <= rx_next_s;
        end
    end

    // Library size captured only when a legal pixel starts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lib_size_r <= CNT_ZERO;
        end else if (start_ok_s) begin
            lib_size_r <= lib_size;
        end else begin
            lib_size_r <= lib_size_r;
        end
    end

    // Sticky error; a new fault wins over the clear from a legal start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            error_r <= 1'b0;
        end else if (err_set_s) begin
            error_r <= 1'b1;
        end else if (start_ok_s) begin
            error_r <= 1'b0;
        end else begin
            error_r <= error_r;
        end
    end

    // Result latch; FLUSH samples the comparator after its register stage settles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            min_value_r <= {WORD_WIDTH{1'b1}};
            min_ref_r   <= {AW{1'b0}};
            max_value_r <= {WORD_WIDTH{1'b0}};
            max_ref_r   <= {AW{1'b0}};
        end else if (state_r == S_FLUSH) begin
            min_value_r <= comp_min_value;
            min_ref_r   <= comp_min_ref;
            max_value_r <= comp_max_value;
            max_ref_r   <= comp_max_ref;
        end else begin
            min_value_r <= min_value_r;
            min_ref_r   <= min_ref_r;
            max_value_r <= max_value_r;
            max_ref_r   <= max_ref_r;
        end
    end

    assign busy          = busy_r;
    assign error         = error_r;
    assign ref_req_valid = req_valid_r;
    assign ref_req_addr  = issue_cnt_r[AW-1:0];
    assign comp_clear    = clear_r;
    assign done          = done_r;
    assign min_value     = min_value_r;
    assign min_ref       = min_ref_r;
    assign max_value     = max_value_r;
    assign max_ref       = max_ref_r;

    // Forwarding path is combinational; dropped results present zeros to the comparator.
    assign comp_in_valid = res_accept_s;
    assign comp_in_value = res_accept_s ? mse_res_value : {WORD_WIDTH{1'b0}};
    assign comp_in_ref   = res_accept_s ? mse_res_ref : {AW{1'b0}};

endmodule

// File: tb/tb_hsi_mse_sched.sv
// Bench for hsi_mse_sched: behavioural MSE datapath and min/max comparator around the DUT,
// table-driven pixel runs with a forwarding scoreboard, plus hand-written corner sequences.
module tb_hsi_mse_sched;

    localparam int WW = 32;
    localparam int LS = 256;
    localparam int AW = 8;
`ifdef HSI_MSE_SCHED_ORDER_CHECK_EN
    localparam bit ORDER_CHK = 1'b1;
`else
    localparam bit ORDER_CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW:0]   lib_size;
    logic          busy, error, ref_req_valid, ref_req_ready;
    logic [AW-1:0] ref_req_addr;
    logic          mse_res_valid;
    logic [WW-1:0] mse_res_value;
    logic [AW-1:0] mse_res_ref;
    logic          comp_clear, comp_in_valid;
    logic [WW-1:0] comp_in_value;
    logic [AW-1:0] comp_in_ref;
    logic [WW-1:0] cmin_v, cmax_v;
    logic [AW-1:0] cmin_r, cmax_r;
    logic          done;
    logic [WW-1:0] min_value, max_value;
    logic [AW-1:0] min_ref, max_ref;

    int checks = 0;
    int errors = 0;
    logic [31:0] vals [LS];

    typedef struct {
        int          n;
        int          rmode;
        int          lat;
        bit          scr;
        bit          poke;
        int          v [8];
        logic [31:0] min_v;
        int          min_r;
        logic [31:0] max_v;
        int          max_r;
        bit          eerr;
        string       nm;
    } vec_t;

    vec_t tbl [7];

    hsi_mse_sched #(.WORD_WIDTH(WW), .HSI_LIBRARY_SIZE(LS), .HSI_LIBRARY_SIZE_ADDR(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .lib_size(lib_size),
        .busy(busy), .error(error),
        .ref_req_valid(ref_req_valid), .ref_req_ready(ref_req_ready), .ref_req_addr(ref_req_addr),
        .mse_res_valid(mse_res_valid), .mse_res_value(mse_res_value), .mse_res_ref(mse_res_ref),
        .comp_clear(comp_clear), .comp_in_valid(comp_in_valid),
        .comp_in_value(comp_in_value), .comp_in_ref(comp_in_ref),
        .comp_min_value(cmin_v), .comp_min_ref(cmin_r),
        .comp_max_value(cmax_v), .comp_max_ref(cmax_r),
        .done(done), .min_value(min_value), .min_ref(min_ref),
        .max_value(max_value), .max_ref(max_ref)
    );

    always #5 clk = ~clk;

    // Registered min/max comparator stand-in; ties take the latest input.
    always @(posedge clk) begin
        if (!rst_n || comp_clear) begin
            cmin_v <= '1; cmin_r <= '0; cmax_v <= '0; cmax_r <= '0;
        end else if (comp_in_valid) begin
            if (comp_in_value <= cmin_v) begin cmin_v <= comp_in_value; cmin_r <= comp_in_ref; end
            if (comp_in_value >= cmax_v) begin cmax_v <= comp_in_value; cmax_r <= comp_in_ref; end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One pixel from start to a few cycles past done; entered and left at posedge+1.
    task automatic run_pixel(input int n, input int rmode, input int lat, input bit scr,
                             input bit poke, input logic [31:0] emin_v, input int emin_r,
                             input logic [31:0] emax_v, input int emax_r, input bit eerr,
                             input string nm);
        int cyc = 0;
        int exp_addr = 0;
        int n_clear = 0;
        int n_done = 0;
        int done_cyc = -1;
        int post = 0;
        int pend_k[$];
        int pend_t[$];
        logic [31:0] sb_v[$];
        int sb_r[$];
        bit prev_stall = 1'b0;
        logic [AW-1:0] prev_addr = '0;
        bit rdy;
        int k;
        int r;
        while (post < 4 && cyc < 2000) begin
            start = (cyc == 0) || (poke && cyc == 3);
            lib_size = (cyc == 0) ? (AW+1)'(n) : 9'd1;
            case (rmode)
                0: rdy = 1'b1;
                1: rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            ref_req_ready = rdy;
            if (prev_stall) begin
                chk({nm, " hold_valid"}, 64'(ref_req_valid), 64'd1);
                chk({nm, " hold_addr"}, 64'(ref_req_addr), 64'(prev_addr));
            end
            if (ref_req_valid && rdy) begin
                chk({nm, " req_addr"}, 64'(ref_req_addr), 64'(exp_addr));
                pend_k.push_back(exp_addr);
                pend_t.push_back(cyc + lat);
                exp_addr++;
            end
            prev_stall = ref_req_valid && !rdy;
            prev_addr = ref_req_addr;
            mse_res_valid = 1'b0; mse_res_value = '0; mse_res_ref = '0;
            if (pend_k.size() > 0 && pend_t[0] <= cyc) begin
                k = pend_k.pop_front();
                void'(pend_t.pop_front());
                r = scr ? ((k == 1) ? 2 : (k == 2) ? 1 : k) : k;
                mse_res_valid = 1'b1; mse_res_value = vals[k]; mse_res_ref = AW'(r);
                sb_v.push_back(vals[k]);
                sb_r.push_back(r);
            end
            @(negedge clk);
            if (comp_clear) n_clear++;
            if (comp_in_valid) begin
                if (sb_v.size() == 0) begin
                    chk({nm, " unexpected_fwd"}, 64'd1, 64'd0);
                end else begin
                    chk({nm, " fwd_value"}, 64'(comp_in_value), 64'(sb_v.pop_front()));
                    chk({nm, " fwd_ref"}, 64'(comp_in_ref), 64'(sb_r.pop_front()));
                end
            end
            if (cyc == 1) chk({nm, " err_cleared"}, 64'(error), 64'd0);
            if (done) begin
                n_done++;
                if (n_done == 1) begin
                    done_cyc = cyc;
                    chk({nm, " busy_in_done"}, 64'(busy), 64'd1);
                    chk({nm, " min_value"}, 64'(min_value), 64'(emin_v));
                    chk({nm, " min_ref"}, 64'(min_ref), 64'(emin_r));
                    chk({nm, " max_value"}, 64'(max_value), 64'(emax_v));
                    chk({nm, " max_ref"}, 64'(max_ref), 64'(emax_r));
                end
            end
            if (n_done > 0) post++;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; ref_req_ready = 1'b0; mse_res_valid = 1'b0;
        if (n_done == 0) chk({nm, " timeout"}, 64'd0, 64'd1);
        chk({nm, " issued"}, 64'(exp_addr), 64'(n));
        chk({nm, " clear_pulses"}, 64'(n_clear), 64'd1);
        chk({nm, " done_pulses"}, 64'(n_done), 64'd1);
        chk({nm, " unforwarded"}, 64'(sb_v.size()), 64'd0);
        chk({nm, " error"}, 64'(error), 64'(eerr));
        chk({nm, " idle_busy"}, 64'(busy), 64'd0);
        chk({nm, " min_hold"}, 64'(min_value), 64'(emin_v));
        if (rmode == 0 && lat == 0 && !poke) chk({nm, " done_cycle"}, 64'(done_cyc), 64'(n + 4));
    endtask

    initial begin
        logic [31:0] fmin_v, fmax_v;
        int fmin_r, fmax_r, n_done;
        tbl[0] = '{n:4, rmode:0, lat:0, scr:1'b0, poke:1'b0, v:'{10,5,20,5,0,0,0,0},
                   min_v:32'd5, min_r:3, max_v:32'd20, max_r:2, eerr:1'b0, nm:"basic"};
        tbl[1] = '{n:3, rmode:1, lat:0, scr:1'b0, poke:1'b0, v:'{7,3,9,0,0,0,0,0},
                   min_v:32'd3, min_r:1, max_v:32'd9, max_r:2, eerr:1'b0, nm:"backpressure"};
        tbl[2] = '{n:1, rmode:0, lat:0, scr:1'b0, poke:1'b0, v:'{42,0,0,0,0,0,0,0},
                   min_v:32'd42, min_r:0, max_v:32'd42, max_r:0, eerr:1'b0, nm:"single"};
        tbl[3] = '{n:5, rmode:0, lat:3, scr:1'b0, poke:1'b0, v:'{100,200,50,200,50,0,0,0},
                   min_v:32'd50, min_r:4, max_v:32'd200, max_r:3, eerr:1'b0, nm:"latency"};
        tbl[4] = '{n:3, rmode:1, lat:2, scr:1'b1, poke:1'b0, v:'{1,2,3,0,0,0,0,0},
                   min_v:32'd1, min_r:0, max_v:32'd3, max_r:1, eerr:ORDER_CHK, nm:"order"};
        tbl[5] = '{n:8, rmode:2, lat:1, scr:1'b0, poke:1'b0, v:'{8,8,8,8,8,8,8,8},
                   min_v:32'd8, min_r:7, max_v:32'd8, max_r:7, eerr:1'b0, nm:"ties"};
        tbl[6] = '{n:4, rmode:0, lat:1, scr:1'b0, poke:1'b1, v:'{4,3,2,1,0,0,0,0},
                   min_v:32'd1, min_r:3, max_v:32'd4, max_r:0, eerr:1'b0, nm:"start_poke"};

        rst_n = 1'b0; start = 1'b0; lib_size = '0; ref_req_ready = 1'b0;
        mse_res_valid = 1'b0; mse_res_value = '0; mse_res_ref = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst error", 64'(error), 64'd0);
        chk("rst req_valid", 64'(ref_req_valid), 64'd0);
        chk("rst comp_clear", 64'(comp_clear), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst min_value", 64'(min_value), 64'hFFFF_FFFF);
        chk("rst max_value", 64'(max_value), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < 8; j++) vals[j] = 32'(tbl[i].v[j]);
            run_pixel(tbl[i].n, tbl[i].rmode, tbl[i].lat, tbl[i].scr, tbl[i].poke,
                      tbl[i].min_v, tbl[i].min_r, tbl[i].max_v, tbl[i].max_r,
                      tbl[i].eerr, tbl[i].nm);
        end

        // Full library: values follow a fixed formula; expected min/max from a ties-latest scan.
        fmin_v = '1; fmax_v = '0; fmin_r = 0; fmax_r = 0;
        for (int i = 0; i < LS; i++) begin
            vals[i] = 32'((i * 37 + 11) % 1000 + 5);
            if (vals[i] <= fmin_v) begin fmin_v = vals[i]; fmin_r = i; end
            if (vals[i] >= fmax_v) begin fmax_v = vals[i]; fmax_r = i; end
        end
        run_pixel(LS, 0, 0, 1'b0, 1'b0, fmin_v, fmin_r, fmax_v, fmax_r, 1'b0, "full_lib");

        // Illegal library sizes.
        start = 1'b1; lib_size = 9'd0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("size0 error", 64'(error), 64'd1);
        chk("size0 busy", 64'(busy), 64'd0);
        chk("size0 clear", 64'(comp_clear), 64'd0);
        start = 1'b1; lib_size = 9'd257;
        @(posedge clk); #1;
        start = 1'b0;
        chk("size257 error", 64'(error), 64'd1);
        chk("size257 busy", 64'(busy), 64'd0);
        chk("size257 clear", 64'(comp_clear), 64'd0);
        vals[0] = 32'd77;
        run_pixel(1, 0, 0, 1'b0, 1'b0, 32'd77, 0, 32'd77, 0, 1'b0, "after_bad");

        // Stray result while idle.
        mse_res_valid = 1'b1; mse_res_value = 32'd9; mse_res_ref = 8'd3;
        @(negedge clk);
        chk("stray fwd_valid", 64'(comp_in_valid), 64'd0);
        @(posedge clk); #1;
        mse_res_valid = 1'b0;
        chk("stray error", 64'(error), 64'd1);

        // Reset in the middle of ISSUE abandons the pixel.
        start = 1'b1; lib_size = 9'd6; ref_req_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("mid busy", 64'(busy), 64'd1);
        chk("mid req_valid", 64'(ref_req_valid), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("mrst busy", 64'(busy), 64'd0);
        chk("mrst error", 64'(error), 64'd0);
        chk("mrst req_valid", 64'(ref_req_valid), 64'd0);
        chk("mrst req_addr", 64'(ref_req_addr), 64'd0);
        chk("mrst comp_clear", 64'(comp_clear), 64'd0);
        chk("mrst fwd_valid", 64'(comp_in_valid), 64'd0);
        chk("mrst done", 64'(done), 64'd0);
        chk("mrst min_value", 64'(min_value), 64'hFFFF_FFFF);
        chk("mrst min_ref", 64'(min_ref), 64'd0);
        chk("mrst max_value", 64'(max_value), 64'd0);
        chk("mrst max_ref", 64'(max_ref), 64'd0);
        n_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) n_done++;
        end
        chk("mrst no_done", 64'(n_done), 64'd0);
        ref_req_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
